fetch_sequencer: RTL and testbench
==================================

Name: fetch_sequencer

Overview:
- Owns the fetch PC register and sequences it. Sits between the hazard, branch and CP0 logic and the instruction memory port.
- Selects the next PC from these sources: sequential, branch/jump target (delay-slot semantics), exception entry, and eret return.
- Runs a request/ready handshake to instruction memory.
- Buffers a redirect that arrives while a fetch cannot be accepted.
- Flags address-error fetches without issuing them.

Parameters:
- RESET_PC, 32'h0000_3000, PC value after reset.
- EXC_PC, 32'h0000_4180, exception handler entry.
- PC_MIN, 32'h0000_3000, lowest legal fetch address.
- PC_MAX, 32'h0000_6ffc, highest legal fetch address.

Ports:
- clk, input, 1, system clock; all state changes on posedge.
- reset, input, 1, asynchronous, active-high; forces the reset state immediately.
- stall, input, 1, hazard unit freezes F stage.
- br_valid, input, 1, a branch or jump is taken in the D stage this cycle.
- br_target, input, 32, target for br_valid.
- exc_req, input, 1, take exception (from CP0).
- eret_req, input, 1, return from exception.
- epc, input, 32, return address for eret_req.
- imem_ready, input, 1, instruction memory returns data for imem_addr this cycle.
- imem_req, output, 1, fetch request.
- imem_addr, output, 32, equals pc.
- pc, output, 32, current fetch PC.
- fetch_valid, output, 1, F-stage instruction at pc is delivered this cycle.
- fetch_adel, output, 1, qualifies fetch_valid: the delivered slot is an address-error fetch.
- pend_valid, output, 1, a buffered redirect is held (debug/verification visibility).

Behaviour:
- Reset (async, while high):
  - pc = RESET_PC, state = BOOT, pend_valid = 0, pend_target = 0.
  - imem_req = 0, fetch_valid = 0, fetch_adel = 0.
- State machine states: BOOT, FETCH, HELD.
- BOOT:
  - Lasts exactly 1 cycle after reset deasserts, with imem_req = 0.
  - Always goes to FETCH.
- bad = (pc[1:0] != 0) || pc < PC_MIN || pc > PC_MAX, using unsigned compares.
- In FETCH:
  - imem_req = !stall && !bad && !exc_req && !eret_req.
  - accept = !stall && (bad || imem_ready) && !exc_req && !eret_req.
  - fetch_valid = accept; fetch_adel = accept && bad.
  - A bad PC never drives imem_req and delivers in the same cycle, with no memory wait.
- FETCH with stall = 1 (and no exc_req/eret_req): go to HELD; pc unchanged.
- In HELD:
  - imem_req = 0, fetch_valid = 0.
  - stall = 0: return to FETCH next cycle and refetch the same pc.
- Next-PC priority, evaluated every cycle in FETCH and HELD; the highest-priority true case wins:
  1. exc_req: pc <= EXC_PC, clear pending, state <= FETCH. Any in-flight fetch is killed, so fetch_valid = 0 that cycle even if imem_ready = 1.
  2. eret_req: pc <= epc, clear pending, state <= FETCH, same kill rule as exc_req.
  3. accept && pend_valid: pc <= pend_target, clear pending. A simultaneous br_valid reloads the pending buffer with br_target, so it is not lost.
  4. accept && br_valid: pc <= br_target.
  5. accept: pc <= pc + 4, 32-bit wrap modulo 2^32.
  6. No accept, no exc/eret: pc holds.
     - If br_valid, capture pend_target <= br_target and set pend_valid = 1.
     - A later br_valid before accept overwrites the buffer (last writer wins).
- Delay-slot rule: when a redirect is applied, the instruction accepted that cycle is the delay slot. The target is the PC fetched after it.
- exc_req and eret_req both high: exception wins.
- br_valid in BOOT is ignored; exc_req/eret_req in BOOT are applied and state <= FETCH.
- Reset mid-fetch: request dropped combinationally; pending redirect lost.
- Outputs registered except imem_req, fetch_valid and fetch_adel, which are combinational from state, pc and inputs.

Test Plan:
- Reset then imem_ready = 1 constant, no stall: BOOT 1 cycle with imem_req = 0. Then fetch_valid every cycle, pc = 3000, 3004, 3008, 300c.
- imem_ready low 3 cycles at pc = 3004: pc holds 3004, fetch_valid = 0 for those cycles. On the ready cycle fetch_valid = 1, then pc becomes 3008.
- br_valid with br_target = 3100 while pc = 3008 and imem_ready low; ready two cycles later: pend_valid = 1 meanwhile. Slot 3008 is delivered, then pc = 3100 and pend_valid = 0.
- exc_req at pc = 3010 with imem_ready = 1 and stall = 1: fetch_valid = 0, next pc = 4180, state FETCH. Later eret_req with epc = 3014: pc = 3014, no delivery that cycle.
- br_target = 3002 accepted: pc = 3002, imem_req = 0, fetch_valid = 1 with fetch_adel = 1 the same cycle. Repeat with br_target = 7000, which also yields adel.
- stall high 2 cycles at pc = 300c, then assert async reset mid-cycle: state HELD with imem_req = 0. On reset, pc = 3000 immediately without a clock edge, and pend_valid = 0.

Source files
------------

// File: rtl/fetch_sequencer.sv
// Fetch PC owner: picks the next PC (sequential, delayed branch, exception, eret),
// runs the imem request/ready handshake and parks redirects that arrive before an accept.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] EXC_PC   = 32'h0000_4180,
  parameter logic [31:0] PC_MIN   = 32'h0000_3000,
  parameter logic [31:0] PC_MAX   = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        br_valid,
  input  logic [31:0] br_target,
  input  logic        exc_req,
  input  logic        eret_req,
  input  logic [31:0] epc,
  input  logic        imem_ready,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  output logic [31:0] pc,
  output logic        fetch_valid,
  output logic        fetch_adel,
  output logic        pend_valid,
  output logic [1:0]  fsm_state
);

  // Handshake: imem_req asks for the word at imem_addr; the word is taken in the
  // cycle imem_ready is high while imem_req is high (a bad PC completes with no request).
  typedef enum logic [1:0] {BOOT = 2'd0, FETCH = 2'd1, HELD = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc_nxt;
  logic [31:0] pend_target, pend_target_nxt;
  logic        pend_valid_nxt;
  logic        bad;
  logic        kill;
  logic        accept;

  assign bad  = (pc[1:0] != 2'b00) || (pc < PC_MIN) || (pc > PC_MAX);
  assign kill = exc_req || eret_req;

  always_comb begin
    imem_req = 1'b0;
    accept   = 1'b0;
    if (state == FETCH && !stall && !kill) begin
      imem_req = !bad;
      accept   = bad || imem_ready;
    end
  end

  assign fetch_valid = accept;
  assign fetch_adel  = accept && bad;
  assign imem_addr   = pc;
  assign fsm_state   = state;

  always_comb begin
    state_nxt       = state;
    pc_nxt          = pc;
    pend_valid_nxt  = pend_valid;
    pend_target_nxt = pend_target;
    if (exc_req) begin
      pc_nxt         = EXC_PC;
      pend_valid_nxt = 1'b0;
      state_nxt      = FETCH;
    end else if (eret_req) begin
      pc_nxt         = epc;
      pend_valid_nxt = 1'b0;
      state_nxt      = FETCH;
    end else if (state == BOOT) begin
      state_nxt = FETCH;
    end else begin
      state_nxt = stall ? HELD : FETCH;
      // The slot accepted this cycle is the delay slot; the redirect applies after it.
      if (accept && pend_valid) begin
        pc_nxt         = pend_target;
        pend_valid_nxt = br_valid;
        if (br_valid) pend_target_nxt = br_target;
      end else if (accept && br_valid) begin
        pc_nxt = br_target;
      end else if (accept) begin
        pc_nxt = pc + 32'd4;
      end else if (br_valid) begin
        pend_valid_nxt  = 1'b1;
        pend_target_nxt = br_target;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= BOOT;
      pc          <= RESET_PC;
      pend_valid  <= 1'b0;
      pend_target <= 32'd0;
    end else begin
      state       <= state_nxt;
      pc          <= pc_nxt;
      pend_valid  <= pend_valid_nxt;
      pend_target <= pend_target_nxt;
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a queue-based fetch model.
module tb_fetch_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] EXC_PC   = 32'h0000_4180;
  localparam logic [31:0] PC_MIN   = 32'h0000_3000;
  localparam logic [31:0] PC_MAX   = 32'h0000_6ffc;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        br_valid = 1'b0;
  logic [31:0] br_target = 32'd0;
  logic        exc_req = 1'b0;
  logic        eret_req = 1'b0;
  logic [31:0] epc = 32'd0;
  logic        imem_ready = 1'b0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] pc;
  logic        fetch_valid;
  logic        fetch_adel;
  logic        pend_valid;
  logic [1:0]  fsm_state;

  int vectors = 0;
  int miscompares = 0;

  fetch_sequencer dut (
    .clk(clk), .reset(reset), .stall(stall), .br_valid(br_valid), .br_target(br_target),
    .exc_req(exc_req), .eret_req(eret_req), .epc(epc), .imem_ready(imem_ready),
    .imem_req(imem_req), .imem_addr(imem_addr), .pc(pc), .fetch_valid(fetch_valid),
    .fetch_adel(fetch_adel), .pend_valid(pend_valid), .fsm_state(fsm_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return (a[1:0] != 2'b00) || (a < PC_MIN) || (a > PC_MAX);
  endfunction

  // ---------------- behavioural model ----------------
  // F stage seen as: waiting out the boot cycle, frozen by a stall, or live.
  // Parked redirects live in a queue of at most one entry.
  logic [31:0] m_pc = RESET_PC;
  bit          m_boot = 1'b1;
  bit          m_frozen = 1'b0;
  logic [31:0] pend_q[$];

  always @(negedge clk) begin
    bit live, acc, req;
    logic [1:0] exp_state;
    if (reset) begin
      m_pc = RESET_PC; m_boot = 1'b1; m_frozen = 1'b0; pend_q.delete();
      check("rst_pc", pc, RESET_PC);
      check("rst_req", {31'd0, imem_req}, 32'd0);
      check("rst_valid", {31'd0, fetch_valid}, 32'd0);
      check("rst_pend", {31'd0, pend_valid}, 32'd0);
    end else begin
      live = !m_boot && !m_frozen;
      req  = live && !stall && !exc_req && !eret_req && !is_bad(m_pc);
      acc  = live && !stall && !exc_req && !eret_req && (is_bad(m_pc) || imem_ready);
      exp_state = m_boot ? 2'd0 : (m_frozen ? 2'd2 : 2'd1);
      check("pc", pc, m_pc);
      check("imem_addr", imem_addr, m_pc);
      check("imem_req", {31'd0, imem_req}, {31'd0, req});
      check("fetch_valid", {31'd0, fetch_valid}, {31'd0, acc});
      check("fetch_adel", {31'd0, fetch_adel}, {31'd0, acc && is_bad(m_pc)});
      check("pend_valid", {31'd0, pend_valid}, {31'd0, pend_q.size() != 0});
      check("state", {30'd0, fsm_state}, {30'd0, exp_state});
      if (exc_req || eret_req) begin
        m_pc = exc_req ? EXC_PC : epc;
        pend_q.delete(); m_boot = 1'b0; m_frozen = 1'b0;
      end else if (m_boot) begin
        m_boot = 1'b0;
      end else begin
        if (acc) begin
          if (pend_q.size() != 0) begin
            m_pc = pend_q.pop_front();
            if (br_valid) pend_q.push_back(br_target);
          end else if (br_valid) m_pc = br_target;
          else m_pc = m_pc + 32'd4;
        end else if (br_valid) begin
          pend_q.delete();
          pend_q.push_back(br_target);
        end
        m_frozen = stall;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic drive(input logic s, input logic b, input logic [31:0] bt, input logic e,
                       input logic r, input logic [31:0] ep, input logic rdy);
    stall = s; br_valid = b; br_target = bt; exc_req = e; eret_req = r; epc = ep;
    imem_ready = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 1);
    check("boot_req", {31'd0, imem_req}, 32'd0);
    check("boot_state", {30'd0, fsm_state}, 32'd0);
    tick();
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] odd [6];
    odd[0] = 32'h0000_3002; odd[1] = 32'h0000_7000; odd[2] = 32'h0000_2ffc;
    odd[3] = 32'hffff_fffc; odd[4] = 32'h0000_6ff8; odd[5] = 32'h0000_6ffc;
    if ($urandom_range(0, 5) == 0) return odd[$urandom_range(0, 5)];
    return PC_MIN + ({20'd0, 12'($urandom_range(0, 4095))} << 2);
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    do_reset();
    // sequential fetch with memory always ready
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 0, 0, 0, 1);
      check("seq_pc", pc, RESET_PC + 32'(4 * i));
      check("seq_valid", {31'd0, fetch_valid}, 32'd1);
      tick();
    end

    // memory wait at 3004
    do_reset();
    drive(0, 0, 0, 0, 0, 0, 1); tick();
    for (int i = 0; i < 3; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      check("wait_pc", pc, 32'h3004);
      check("wait_valid", {31'd0, fetch_valid}, 32'd0);
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 1);
    check("wait_done_valid", {31'd0, fetch_valid}, 32'd1);
    tick();
    check("wait_next_pc", pc, 32'h3008);

    // branch parked while 3008 waits on memory
    drive(0, 1, 32'h3100, 0, 0, 0, 0);
    check("park_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("park_pend", {31'd0, pend_valid}, 32'd1);
    check("park_pc", pc, 32'h3008);
    drive(0, 0, 0, 0, 0, 0, 0); tick();
    drive(0, 0, 0, 0, 0, 0, 1);
    check("slot_valid", {31'd0, fetch_valid}, 32'd1);
    check("slot_pc", pc, 32'h3008);
    tick();
    check("redir_pc", pc, 32'h3100);
    check("redir_pend", {31'd0, pend_valid}, 32'd0);

    // exception kills a fetch, eret returns
    do_reset();
    for (int i = 0; i < 4; i++) begin drive(0, 0, 0, 0, 0, 0, 1); tick(); end
    check("pre_exc_pc", pc, 32'h3010);
    drive(1, 0, 0, 1, 0, 0, 1);
    check("exc_valid", {31'd0, fetch_valid}, 32'd0);
    check("exc_req_out", {31'd0, imem_req}, 32'd0);
    tick();
    check("exc_pc", pc, EXC_PC);
    check("exc_state", {30'd0, fsm_state}, 32'd1);
    drive(0, 0, 0, 0, 1, 32'h3014, 1);
    check("eret_valid", {31'd0, fetch_valid}, 32'd0);
    tick();
    check("eret_pc", pc, 32'h3014);

    // address-error targets deliver immediately with no request
    drive(0, 1, 32'h3002, 0, 0, 0, 1); tick();
    check("adel1_pc", pc, 32'h3002);
    drive(0, 1, 32'h7000, 0, 0, 0, 0);
    check("adel1_req", {31'd0, imem_req}, 32'd0);
    check("adel1_valid", {31'd0, fetch_valid}, 32'd1);
    check("adel1_flag", {31'd0, fetch_adel}, 32'd1);
    tick();
    check("adel2_pc", pc, 32'h7000);
    drive(0, 1, 32'h3020, 0, 0, 0, 0);
    check("adel2_req", {31'd0, imem_req}, 32'd0);
    check("adel2_valid", {31'd0, fetch_valid}, 32'd1);
    check("adel2_flag", {31'd0, fetch_adel}, 32'd1);
    tick();
    check("adel_exit_pc", pc, 32'h3020);

    // stall into HELD, then asynchronous reset mid-cycle
    do_reset();
    for (int i = 0; i < 3; i++) begin drive(0, 0, 0, 0, 0, 0, 1); tick(); end
    drive(1, 0, 0, 0, 0, 0, 1);
    check("stall_req", {31'd0, imem_req}, 32'd0);
    tick();
    drive(1, 1, 32'h3200, 0, 0, 0, 1);
    check("held_state", {30'd0, fsm_state}, 32'd2);
    check("held_req", {31'd0, imem_req}, 32'd0);
    check("held_pc", pc, 32'h300c);
    tick();
    check("held_pend", {31'd0, pend_valid}, 32'd1);
    #1;
    reset = 1'b1;
    #1;
    check("async_pc", pc, RESET_PC);
    check("async_pend", {31'd0, pend_valid}, 32'd0);
    check("async_state", {30'd0, fsm_state}, 32'd0);
    check("async_req", {31'd0, imem_req}, 32'd0);

    // randomized traffic, model-checked every cycle
    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if ($urandom_range(0, 399) == 0) begin
        do_reset();
      end else begin
        drive($urandom_range(0, 9) < 2, $urandom_range(0, 5) == 0, pick_addr(),
              $urandom_range(0, 63) == 0, $urandom_range(0, 47) == 0, pick_addr(),
              $urandom_range(0, 3) != 0);
        tick();
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
